// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite master: response codes and engine state encodings.
// The optional watchdog is enabled with the AXI4_TIMEOUT_EN macro.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE      = 2'd0,
        WR_ADDR_DATA = 2'd1,
        WR_RESP      = 2'd2
    } wr_state_e;

endpackage

// File: rtl/axi4_lite_watchdog.sv
// Per-engine cycle counter: counts busy cycles and flags a timeout on the
// LIMIT-th one. Only instantiated when AXI4_TIMEOUT_EN is defined.
module axi4_lite_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active_i,
    output logic timeout_o
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!active_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // cnt_q holds the number of busy cycles already completed, so this fires in the last allowed one.
    assign timeout_o = active_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/axi4_lite_master_ctrl.sv
// AXI4-Lite master with independent read and write engines driven by simple
// valid/ready requests. Define AXI4_TIMEOUT_EN to add a per-engine watchdog.
module axi4_lite_master_ctrl
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  iClock,
    input  logic                  iReset,
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // a valid, once raised, is held with stable payload until that edge.
    input  logic                  iRdReqValid,
    output logic                  oRdReqReady,
    input  logic [ADDR_WIDTH-1:0] iRdReqAddr,
    output logic                  oRdRspValid,
    output logic [DATA_WIDTH-1:0] oRdRspData,
    output logic [1:0]            oRdRspResp,
    input  logic                  iWrReqValid,
    output logic                  oWrReqReady,
    input  logic [ADDR_WIDTH-1:0] iWrReqAddr,
    input  logic [DATA_WIDTH-1:0] iWrReqData,
    input  logic [STRB_WIDTH-1:0] iWrReqStrb,
    output logic                  oWrRspValid,
    output logic [1:0]            oWrRspResp,
    output logic [1:0]            oDbgRdState,
    output logic [1:0]            oDbgWrState,
    input  logic                  pAXI4_ar_ready,
    output logic                  pAXI4_ar_valid,
    output logic [ADDR_WIDTH-1:0] pAXI4_ar_bits_addr,
    input  logic                  pAXI4_r_valid,
    input  logic [DATA_WIDTH-1:0] pAXI4_r_bits_data,
    input  logic [1:0]            pAXI4_r_bits_resp,
    output logic                  pAXI4_r_ready,
    input  logic                  pAXI4_aw_ready,
    output logic                  pAXI4_aw_valid,
    output logic [ADDR_WIDTH-1:0] pAXI4_aw_bits_addr,
    input  logic                  pAXI4_w_ready,
    output logic                  pAXI4_w_valid,
    output logic [DATA_WIDTH-1:0] pAXI4_w_bits_data,
    output logic [STRB_WIDTH-1:0] pAXI4_w_bits_strb,
    input  logic                  pAXI4_b_valid,
    input  logic [1:0]            pAXI4_b_bits_resp,
    output logic                  pAXI4_b_ready
);

    rd_state_e             rd_state_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [1:0]            rd_resp_q;
    logic                  rd_rsp_valid_q;

    wr_state_e             wr_state_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [STRB_WIDTH-1:0] wr_strb_q;
    logic [1:0]            wr_resp_q;
    logic                  wr_rsp_valid_q;
    logic                  aw_valid_q, w_valid_q;
    logic                  aw_done_q, w_done_q;

    logic rd_timeout, wr_timeout;
    logic aw_fire, w_fire;

`ifdef AXI4_TIMEOUT_EN
    axi4_lite_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_rd_wdog (
        .clk_i    (iClock),
        .rst_ni   (iReset),
        .active_i (rd_state_q != RD_IDLE),
        .timeout_o(rd_timeout)
    );

    axi4_lite_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wr_wdog (
        .clk_i    (iClock),
        .rst_ni   (iReset),
        .active_i (wr_state_q != WR_IDLE),
        .timeout_o(wr_timeout)
    );
`else
    assign rd_timeout = 1'b0;
    assign wr_timeout = 1'b0;
`endif

    // Read engine; a watchdog expiry overrides any handshake in the same cycle.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            rd_state_q     <= RD_IDLE;
            rd_addr_q      <= '0;
            rd_data_q      <= '0;
            rd_resp_q      <= RESP_OKAY;
            rd_rsp_valid_q <= 1'b0;
        end else begin
            rd_rsp_valid_q <= 1'b0;
            if (rd_timeout) begin
                rd_state_q     <= RD_IDLE;
                rd_data_q      <= '0;
                rd_resp_q      <= RESP_DECERR;
                rd_rsp_valid_q <= 1'b1;
            end else begin
                case (rd_state_q)
                    RD_IDLE: begin
                        if (iRdReqValid) begin
                            rd_addr_q  <= iRdReqAddr;
                            rd_state_q <= RD_ADDR;
                        end
                    end
                    RD_ADDR: begin
                        if (pAXI4_ar_ready) rd_state_q <= RD_DATA;
                    end
                    RD_DATA: begin
                        if (pAXI4_r_valid) begin
                            rd_data_q      <= pAXI4_r_bits_data;
                            rd_resp_q      <= pAXI4_r_bits_resp;
                            rd_rsp_valid_q <= 1'b1;
                            rd_state_q     <= RD_IDLE;
                        end
                    end
                    default: rd_state_q <= RD_IDLE;
                endcase
            end
        end
    end

    assign aw_fire = aw_valid_q && pAXI4_aw_ready;
    assign w_fire  = w_valid_q && pAXI4_w_ready;

    // Write engine: AW and W complete in either order, or together.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            wr_state_q     <= WR_IDLE;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            wr_strb_q      <= '0;
            wr_resp_q      <= RESP_OKAY;
            wr_rsp_valid_q <= 1'b0;
            aw_valid_q     <= 1'b0;
            w_valid_q      <= 1'b0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
        end else begin
            wr_rsp_valid_q <= 1'b0;
            if (wr_timeout) begin
                wr_state_q     <= WR_IDLE;
                wr_resp_q      <= RESP_DECERR;
                wr_rsp_valid_q <= 1'b1;
                aw_valid_q     <= 1'b0;
                w_valid_q      <= 1'b0;
                aw_done_q      <= 1'b0;
                w_done_q       <= 1'b0;
            end else begin
                case (wr_state_q)
                    WR_IDLE: begin
                        if (iWrReqValid) begin
                            wr_addr_q  <= iWrReqAddr;
                            wr_data_q  <= iWrReqData;
                            wr_strb_q  <= iWrReqStrb;
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            wr_state_q <= WR_ADDR_DATA;
                        end
                    end
                    WR_ADDR_DATA: begin
                        if (aw_fire) begin
                            aw_valid_q <= 1'b0;
                            aw_done_q  <= 1'b1;
                        end
                        if (w_fire) begin
                            w_valid_q <= 1'b0;
                            w_done_q  <= 1'b1;
                        end
                        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                            aw_done_q  <= 1'b0;
                            w_done_q   <= 1'b0;
                            wr_state_q <= WR_RESP;
                        end
                    end
                    WR_RESP: begin
                        if (pAXI4_b_valid) begin
                            wr_resp_q      <= pAXI4_b_bits_resp;
                            wr_rsp_valid_q <= 1'b1;
                            wr_state_q     <= WR_IDLE;
                        end
                    end
                    default: wr_state_q <= WR_IDLE;
                endcase
            end
        end
    end

    assign oRdReqReady        = (rd_state_q == RD_IDLE);
    assign oRdRspValid        = rd_rsp_valid_q;
    assign oRdRspData         = rd_data_q;
    assign oRdRspResp         = rd_resp_q;
    assign pAXI4_ar_valid     = (rd_state_q == RD_ADDR);
    assign pAXI4_ar_bits_addr = rd_addr_q;
    assign pAXI4_r_ready      = (rd_state_q == RD_DATA);

    assign oWrReqReady        = (wr_state_q == WR_IDLE);
    assign oWrRspValid        = wr_rsp_valid_q;
    assign oWrRspResp         = wr_resp_q;
    assign pAXI4_aw_valid     = aw_valid_q;
    assign pAXI4_aw_bits_addr = wr_addr_q;
    assign pAXI4_w_valid      = w_valid_q;
    assign pAXI4_w_bits_data  = wr_data_q;
    assign pAXI4_w_bits_strb  = wr_strb_q;
    assign pAXI4_b_ready      = (wr_state_q == WR_RESP);

    assign oDbgRdState = rd_state_q;
    assign oDbgWrState = wr_state_q;

endmodule

// File: tb/tb_axi4_lite_master_ctrl.sv
// Directed bench for axi4_lite_master_ctrl; cycle-exact checks against hand-computed values.
// Build with AXI4_TIMEOUT_EN to exercise the watchdog path.
module tb_axi4_lite_master_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk;
    logic          rst_n;
    logic          rd_req_valid, rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic          rd_rsp_valid;
    logic [DW-1:0] rd_rsp_data;
    logic [1:0]    rd_rsp_resp;
    logic          wr_req_valid, wr_req_ready;
    logic [AW-1:0] wr_req_addr;
    logic [DW-1:0] wr_req_data;
    logic [SW-1:0] wr_req_strb;
    logic          wr_rsp_valid;
    logic [1:0]    wr_rsp_resp;
    logic [1:0]    dbg_rd_state, dbg_wr_state;
    logic          ar_ready, ar_valid;
    logic [AW-1:0] ar_addr;
    logic          r_valid, r_ready;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;
    logic          aw_ready, aw_valid;
    logic [AW-1:0] aw_addr;
    logic          w_ready, w_valid;
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;
    logic          b_valid, b_ready;
    logic [1:0]    b_resp;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    axi4_lite_master_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .iClock(clk), .iReset(rst_n),
        .iRdReqValid(rd_req_valid), .oRdReqReady(rd_req_ready), .iRdReqAddr(rd_req_addr),
        .oRdRspValid(rd_rsp_valid), .oRdRspData(rd_rsp_data), .oRdRspResp(rd_rsp_resp),
        .iWrReqValid(wr_req_valid), .oWrReqReady(wr_req_ready), .iWrReqAddr(wr_req_addr),
        .iWrReqData(wr_req_data), .iWrReqStrb(wr_req_strb),
        .oWrRspValid(wr_rsp_valid), .oWrRspResp(wr_rsp_resp),
        .oDbgRdState(dbg_rd_state), .oDbgWrState(dbg_wr_state),
        .pAXI4_ar_ready(ar_ready), .pAXI4_ar_valid(ar_valid), .pAXI4_ar_bits_addr(ar_addr),
        .pAXI4_r_valid(r_valid), .pAXI4_r_bits_data(r_data), .pAXI4_r_bits_resp(r_resp),
        .pAXI4_r_ready(r_ready),
        .pAXI4_aw_ready(aw_ready), .pAXI4_aw_valid(aw_valid), .pAXI4_aw_bits_addr(aw_addr),
        .pAXI4_w_ready(w_ready), .pAXI4_w_valid(w_valid), .pAXI4_w_bits_data(w_data),
        .pAXI4_w_bits_strb(w_strb),
        .pAXI4_b_valid(b_valid), .pAXI4_b_bits_resp(b_resp), .pAXI4_b_ready(b_ready)
    );

    // Clock and run-time guard
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    // Driver helpers: inputs change and outputs are sampled 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        ar_ready = 0; r_valid = 0; r_data = '0; r_resp = 2'b00;
        aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 2'b00;
    endtask

    task automatic wait_rd_rsp(input int max_cycles, output int waited);
        waited = 0;
        while (!rd_rsp_valid && waited < max_cycles) begin
            tick();
            waited++;
        end
    endtask

    initial begin
        int waited;
        int early;
        logic [DW-1:0] exp_data;

        rd_req_valid = 0; rd_req_addr = '0;
        wr_req_valid = 0; wr_req_addr = '0; wr_req_data = '0; wr_req_strb = '0;
        slave_idle();

        // Reset state
        rst_n = 0;
        #12;
        check("rst_ar_valid", ar_valid, 0);
        check("rst_aw_w_valid", {aw_valid, w_valid, r_ready, b_ready}, 0);
        check("rst_rsp_pulses", {rd_rsp_valid, wr_rsp_valid}, 0);
        check("rst_rd_data_resp", {rd_rsp_data, rd_rsp_resp, wr_rsp_resp}, 0);
        check("rst_states", {dbg_rd_state, dbg_wr_state}, 0);
        tick();
        rst_n = 1;
        tick();
        check("rst_req_ready", {rd_req_ready, wr_req_ready}, 2'b11);

        // 1: zero-wait read of 0x8000_0000 returning 0xDEAD_BEEF/OKAY
        ar_ready = 1; r_valid = 1; r_data = 32'hDEAD_BEEF; r_resp = 2'b00;
        rd_req_valid = 1; rd_req_addr = 32'h8000_0000;
        exp_q.push_back(32'hDEAD_BEEF);
        tick();                                  // T+1
        rd_req_valid = 0; rd_req_addr = 32'hFFFF_FFFF;
        check("rd1_t1_ar_valid", {ar_valid, r_ready, rd_req_ready}, 3'b100);
        check("rd1_t1_ar_addr", ar_addr, 32'h8000_0000);
        tick();                                  // T+2
        check("rd1_t2_r_ready", {ar_valid, r_ready, rd_rsp_valid}, 3'b010);
        tick();                                  // T+3
        exp_data = exp_q.pop_front();
        check("rd1_t3_pulse", {rd_rsp_valid, rd_req_ready}, 2'b11);
        check("rd1_t3_data", rd_rsp_data, exp_data);
        check("rd1_t3_resp", rd_rsp_resp, 2'b00);
        r_data = 32'h1111_1111;
        tick();                                  // T+4
        check("rd1_t4_pulse_drop", rd_rsp_valid, 0);
        check("rd1_t4_data_held", rd_rsp_data, 32'hDEAD_BEEF);
        slave_idle();

        // 2: write, aw_ready immediate, w_ready delayed to T+4, BRESP EXOKAY
        aw_ready = 1; b_valid = 1; b_resp = 2'b01;
        wr_req_valid = 1; wr_req_addr = 32'h8000_0010; wr_req_data = 32'h1234_5678; wr_req_strb = 4'b0011;
        tick();                                  // T+1
        wr_req_valid = 0; wr_req_data = '0;
        check("wr2_t1_valids", {aw_valid, w_valid, wr_req_ready}, 3'b110);
        check("wr2_t1_payload", {aw_addr, w_data, w_strb}, {32'h8000_0010, 32'h1234_5678, 4'b0011});
        tick();                                  // T+2
        check("wr2_t2_aw_drop", {aw_valid, w_valid}, 2'b01);
        tick();                                  // T+3
        check("wr2_t3_w_held", {aw_valid, w_valid, b_ready}, 3'b010);
        tick();                                  // T+4
        w_ready = 1;
        check("wr2_t4_w_held", w_valid, 1);
        tick();                                  // T+5
        w_ready = 0;
        check("wr2_t5_b_ready", {w_valid, b_ready, wr_rsp_valid}, 3'b010);
        tick();                                  // T+6
        check("wr2_t6_pulse", {wr_rsp_valid, wr_req_ready, b_ready}, 3'b110);
        check("wr2_t6_bresp", wr_rsp_resp, 2'b01);
        slave_idle();

        // 3: W accepted before AW, slave returns SLVERR
        w_ready = 1; b_valid = 1; b_resp = 2'b10;
        wr_req_valid = 1; wr_req_addr = 32'h8000_0020; wr_req_data = 32'hA5A5_5A5A; wr_req_strb = 4'b1111;
        tick();                                  // T+1
        wr_req_valid = 0;
        check("wr3_t1_valids", {aw_valid, w_valid}, 2'b11);
        tick();                                  // T+2
        aw_ready = 1;
        check("wr3_t2_w_drop", {aw_valid, w_valid, b_ready}, 3'b100);
        tick();                                  // T+3
        check("wr3_t3_b_ready", {aw_valid, b_ready, wr_rsp_valid}, 3'b010);
        tick();                                  // T+4
        check("wr3_t4_slverr", {wr_rsp_valid, wr_rsp_resp}, 3'b110);
        slave_idle();

        // 4: concurrent read (DECERR from slave) and write, then back-to-back read
        ar_ready = 1; r_valid = 1; r_data = 32'hCAFE_F00D; r_resp = 2'b11;
        aw_ready = 1; w_ready = 1; b_valid = 1; b_resp = 2'b00;
        rd_req_valid = 1; rd_req_addr = 32'h0000_0100;
        wr_req_valid = 1; wr_req_addr = 32'h0000_0200; wr_req_data = 32'h0F0F_0F0F; wr_req_strb = 4'b1100;
        tick();                                  // T+1
        rd_req_valid = 0; wr_req_valid = 0;
        check("cc_t1_all_valid", {ar_valid, aw_valid, w_valid}, 3'b111);
        tick();                                  // T+2
        check("cc_t2_ready", {r_ready, b_ready}, 2'b11);
        tick();                                  // T+3
        check("cc_t3_pulses", {rd_rsp_valid, wr_rsp_valid}, 2'b11);
        check("cc_t3_rd", {rd_rsp_data, rd_rsp_resp}, {32'hCAFE_F00D, 2'b11});
        check("cc_t3_wr_resp", wr_rsp_resp, 2'b00);
        r_data = 32'h0BAD_C0DE; r_resp = 2'b00;
        rd_req_valid = 1; rd_req_addr = 32'h0000_0104;
        exp_q.push_back(32'h0BAD_C0DE);
        tick();                                  // T+4
        rd_req_valid = 0;
        check("b2b_ar_valid", {ar_valid, ar_addr}, {1'b1, 32'h0000_0104});
        tick();
        tick();                                  // T+6
        exp_data = exp_q.pop_front();
        check("b2b_pulse", {rd_rsp_valid, rd_rsp_resp}, 3'b100);
        check("b2b_data", rd_rsp_data, exp_data);
        slave_idle();

        // 5: reset while in RD_DATA abandons the read
        ar_ready = 1;
        rd_req_valid = 1; rd_req_addr = 32'h0000_0300;
        tick();
        rd_req_valid = 0;
        tick();
        check("rr_in_rd_data", {r_ready, dbg_rd_state}, {1'b1, 2'd2});
        rst_n = 0;
        #1;
        check("rr_outputs_low", {ar_valid, r_ready, rd_rsp_valid, dbg_rd_state}, 0);
        check("rr_data_cleared", rd_rsp_data, 0);
        r_valid = 1; r_data = 32'h7777_7777;
        tick();
        rst_n = 1;
        early = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rd_rsp_valid) early++;
        end
        check("rr_no_pulse", early, 0);
        check("rr_req_ready", {rd_req_ready, r_ready}, 2'b10);
        slave_idle();

        // 6: ar_ready withheld
        rd_req_valid = 1; rd_req_addr = 32'h0000_0400;
        tick();                                  // T+1
        rd_req_valid = 0;
`ifdef AXI4_TIMEOUT_EN
        early = 0;
        for (int i = 1; i < 17; i++) begin       // T+1 .. T+16
            if (rd_rsp_valid || !ar_valid) early++;
            tick();
        end
        check("wd_no_early", early, 0);
        check("wd_pulse", {rd_rsp_valid, rd_rsp_resp, ar_valid}, 4'b1110);
        check("wd_data_zero", rd_rsp_data, 0);
`else
        early = 0;
        for (int i = 0; i < 40; i++) begin
            if (rd_rsp_valid || !ar_valid) early++;
            tick();
        end
        check("nowd_waits", early, 0);
        ar_ready = 1; r_valid = 1; r_data = 32'h4444_0400; r_resp = 2'b10;
        wait_rd_rsp(10, waited);
        check("nowd_completes", waited, 2);
        check("nowd_rsp", {rd_rsp_valid, rd_rsp_data, rd_rsp_resp}, {1'b1, 32'h4444_0400, 2'b10});
`endif
        slave_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
